// File: rtl/ttl_decade_counter_decoder_pkg.sv
// ttl_decade_counter_decoder_pkg: shared BCD limits, one-of-ten decode table and load sanitiser.
package ttl_decade_counter_decoder_pkg;
  localparam int WIDTH_IN = 4;
  localparam int WIDTH_OUT = 10;
  localparam logic [WIDTH_IN-1:0] BCD_MAX = 4'd9;
  localparam logic [WIDTH_IN-1:0] BCD_MIN = 4'd0;
  // Entry k drives line k low; entry 9 is the leftmost element.
  localparam logic [9:0][WIDTH_OUT-1:0] DECODE_TBL = {
    10'h1FF, 10'h2FF, 10'h37F, 10'h3BF, 10'h3DF,
    10'h3EF, 10'h3F7, 10'h3FB, 10'h3FD, 10'h3FE
  };
  function automatic logic [WIDTH_IN-1:0] bcd_sanitize(input logic [WIDTH_IN-1:0] v);
    return (v > BCD_MAX) ? BCD_MIN : v;
  endfunction
endpackage

// File: rtl/ttl_bcd_to_decimal.sv
// ttl_bcd_to_decimal: combinational BCD to ten active-low lines; non-BCD codes give all-ones.
module ttl_bcd_to_decimal
  import ttl_decade_counter_decoder_pkg::*;
(
  input  logic [WIDTH_IN-1:0]  i_bcd,
  output logic [WIDTH_OUT-1:0] o_y_bar
);
  assign o_y_bar = (i_bcd <= BCD_MAX) ? DECODE_TBL[i_bcd] : '1;
endmodule

// File: rtl/ttl_decade_counter_decoder.sv
// ttl_decade_counter_decoder: up/down decade counter with one-of-ten active-low decode.
// Define DECADE_INVERTED_LOAD_EN to accept an active-low BCD load bus.
module ttl_decade_counter_decoder
  import ttl_decade_counter_decoder_pkg::*;
(
  input  logic                 i_clk,
  input  logic                 i_clear_bar,
  input  logic                 i_load_bar,
  input  logic                 i_enable,
  input  logic                 i_down,
  input  logic [WIDTH_IN-1:0]  i_d,
  output logic [WIDTH_IN-1:0]  o_q,
  output logic [WIDTH_OUT-1:0] o_y_bar,
  output logic                 o_tc_bar
);
  logic [WIDTH_IN-1:0] r_q;
  logic [WIDTH_IN-1:0] w_d;
  logic [WIDTH_IN-1:0] w_cnt;
  logic [WIDTH_IN-1:0] w_next;
  logic                w_at_max;
  logic                w_at_min;
`ifdef DECADE_INVERTED_LOAD_EN
  assign w_d = ~i_d;
`else
  assign w_d = i_d;
`endif
  assign w_at_max = (r_q == BCD_MAX);
  assign w_at_min = (r_q == BCD_MIN);
  always_comb begin
    w_cnt = i_down ? (w_at_min ? BCD_MAX : r_q - 4'd1) : (w_at_max ? BCD_MIN : r_q + 4'd1);
    w_next = !i_load_bar ? bcd_sanitize(w_d) : i_enable ? w_cnt : r_q;
  end
  always_ff @(posedge i_clk or negedge i_clear_bar)
    if (!i_clear_bar) r_q <= BCD_MIN;
    else r_q <= w_next;
  ttl_bcd_to_decimal u_dec (
    .i_bcd  (r_q),
    .o_y_bar(o_y_bar)
  );
  assign o_q = r_q;
  assign o_tc_bar = ~(i_enable & i_load_bar & (i_down ? w_at_min : w_at_max));
endmodule

// File: tb/tb_ttl_decade_counter_decoder.sv
// tb_ttl_decade_counter_decoder: randomized and directed checks against a decimal reference model.
module tb_ttl_decade_counter_decoder;
  logic clk = 0, clear_n = 0, load_bar = 1, en = 0, down = 0, cas_en = 0;
  logic [3:0] d = 0;
  logic [3:0] q, q2;
  logic [9:0] y, y2;
  logic tc, tc2;
  int errors = 0, checks = 0, m = 0;

  always #5 clk = ~clk;

  ttl_decade_counter_decoder dut (
    .i_clk(clk), .i_clear_bar(clear_n), .i_load_bar(load_bar), .i_enable(en),
    .i_down(down), .i_d(d), .o_q(q), .o_y_bar(y), .o_tc_bar(tc)
  );
  ttl_decade_counter_decoder dut_hi (
    .i_clk(clk), .i_clear_bar(clear_n), .i_load_bar(1'b1), .i_enable(cas_en & ~tc),
    .i_down(1'b0), .i_d(4'd0), .o_q(q2), .o_y_bar(y2), .o_tc_bar(tc2)
  );

  function automatic int ldval(input logic [3:0] dv);
    int v;
`ifdef DECADE_INVERTED_LOAD_EN
    v = 15 - int'(dv);
`else
    v = int'(dv);
`endif
    return (v > 9) ? 0 : v;
  endfunction

  function automatic logic [3:0] enc(input int v);
`ifdef DECADE_INVERTED_LOAD_EN
    return 4'(15 - v);
`else
    return 4'(v);
`endif
  endfunction

  function automatic int nxt(input int cur);
    if (!load_bar) return ldval(d);
    if (en) return down ? (cur + 9) % 10 : (cur + 1) % 10;
    return cur;
  endfunction

  function automatic logic exp_tc(input int cur);
    return !(en && load_bar && (down ? cur == 0 : cur == 9));
  endfunction

  function automatic logic [9:0] exp_y(input int cur);
    return 10'h3FF ^ (10'd1 << cur);
  endfunction

  task automatic step();
    int n;
    n = nxt(m);
    @(posedge clk);
    #1;
    m = n;
  endtask

  task automatic test_reset();
    #2;
    checks++; if (q !== 4'd0) begin errors++; $display("FAIL reset_q got=%0d exp=0", q); end
    checks++; if (y !== 10'h3FE) begin errors++; $display("FAIL reset_y got=%h exp=3fe", y); end
    checks++; if (tc !== 1'b1) begin errors++; $display("FAIL reset_tc got=%b exp=1", tc); end
    @(negedge clk);
    clear_n = 1;
    m = 0;
  endtask

  task automatic test_async_clear();
    en = 1; down = 0;
    repeat (6) step();
    checks++; if (q !== 4'd6) begin errors++; $display("FAIL pre_clear_q got=%0d exp=6", q); end
    #2 clear_n = 0;
    #1;
    checks++; if (q !== 4'd0) begin errors++; $display("FAIL aclr_q got=%0d exp=0", q); end
    checks++; if (y !== 10'h3FE) begin errors++; $display("FAIL aclr_y got=%h exp=3fe", y); end
    checks++; if (tc !== 1'b1) begin errors++; $display("FAIL aclr_tc got=%b exp=1", tc); end
    m = 0;
    @(negedge clk);
    clear_n = 1;
  endtask

  task automatic test_count_up();
    en = 1; down = 0; load_bar = 1;
    for (int i = 0; i < 12; i++) begin
      checks++; if (tc !== ((i % 10) != 9)) begin errors++; $display("FAIL up_tc i=%0d got=%b q=%0d", i, tc, q); end
      step();
      checks++; if (q !== 4'((i + 1) % 10)) begin errors++; $display("FAIL up_q i=%0d got=%0d exp=%0d", i, q, (i + 1) % 10); end
      checks++; if (y !== exp_y((i + 1) % 10)) begin errors++; $display("FAIL up_y i=%0d got=%h exp=%h", i, y, exp_y((i + 1) % 10)); end
    end
  endtask

  task automatic test_count_down();
    int exp_seq[3] = '{0, 9, 8};
    logic tcs[3] = '{1'b1, 1'b0, 1'b1};
    en = 1; down = 1;
    step();
    checks++; if (q !== 4'd1) begin errors++; $display("FAIL dn_start got=%0d exp=1", q); end
    for (int i = 0; i < 3; i++) begin
      checks++; if (tc !== tcs[i]) begin errors++; $display("FAIL dn_tc i=%0d got=%b exp=%b", i, tc, tcs[i]); end
      step();
      checks++; if (q !== 4'(exp_seq[i])) begin errors++; $display("FAIL dn_q i=%0d got=%0d exp=%0d", i, q, exp_seq[i]); end
    end
  endtask

  task automatic test_load();
    logic [3:0] vals[5] = '{4'd7, 4'd12, 4'b1000, 4'd15, 4'd3};
    en = 1; down = 0; load_bar = 0;
    for (int i = 0; i < 5; i++) begin
      d = vals[i];
      #1;
      checks++; if (tc !== 1'b1) begin errors++; $display("FAIL load_tc d=%0d got=%b exp=1", d, tc); end
      step();
      checks++; if (q !== 4'(ldval(vals[i]))) begin errors++; $display("FAIL load_q d=%0d got=%0d exp=%0d", vals[i], q, ldval(vals[i])); end
      checks++; if (y !== exp_y(ldval(vals[i]))) begin errors++; $display("FAIL load_y d=%0d got=%h exp=%h", vals[i], y, exp_y(ldval(vals[i]))); end
    end
    d = enc(7);
    step();
    checks++; if (q !== 4'd7 || y !== 10'b1101111111) begin errors++; $display("FAIL load7 got q=%0d y=%h exp q=7 y=37f", q, y); end
    load_bar = 1;
  endtask

  task automatic test_hold();
    load_bar = 0; d = enc(4);
    step();
    load_bar = 1; en = 0;
    for (int i = 0; i < 5; i++) begin
      d = 4'($urandom_range(0, 15)); down = 1'($urandom_range(0, 1));
      #1;
      checks++; if (tc !== 1'b1) begin errors++; $display("FAIL hold_tc i=%0d got=%b exp=1", i, tc); end
      step();
      checks++; if (q !== 4'd4) begin errors++; $display("FAIL hold_q i=%0d got=%0d exp=4", i, q); end
    end
  endtask

  task automatic test_random();
    for (int i = 0; i < 300; i++) begin
      load_bar = ($urandom_range(0, 7) != 0);
      en = 1'($urandom_range(0, 3) != 0);
      down = 1'($urandom_range(0, 1));
      d = 4'($urandom_range(0, 15));
      #1;
      checks++; if (tc !== exp_tc(m)) begin errors++; $display("FAIL rnd_tc i=%0d got=%b exp=%b", i, tc, exp_tc(m)); end
      if ($urandom_range(0, 49) == 0) begin
        clear_n = 0;
        #1;
        m = 0;
        checks++; if (q !== 4'd0) begin errors++; $display("FAIL rnd_clr i=%0d got=%0d exp=0", i, q); end
        @(negedge clk);
        clear_n = 1;
      end else begin
        step();
        checks++; if (q !== 4'(m) || y !== exp_y(m)) begin errors++; $display("FAIL rnd_q i=%0d got q=%0d y=%h exp q=%0d y=%h", i, q, y, m, exp_y(m)); end
      end
    end
    load_bar = 1;
  endtask

  task automatic test_cascade();
    int bad = 0;
    @(negedge clk);
    clear_n = 0;
    #1 clear_n = 1;
    en = 1; down = 0; load_bar = 1; cas_en = 1;
    for (int i = 1; i <= 100; i++) begin
      @(posedge clk);
      #1;
      checks++;
      if (q !== 4'(i % 10) || q2 !== 4'((i / 10) % 10)) begin
        errors++;
        if (bad++ < 5) $display("FAIL cascade i=%0d got=%0d%0d exp=%0d%0d", i, q2, q, (i / 10) % 10, i % 10);
      end
    end
    checks++; if (y2 !== 10'h3FE || y !== 10'h3FE) begin errors++; $display("FAIL cascade_wrap got y_hi=%h y_lo=%h exp 3fe", y2, y); end
    cas_en = 0;
  endtask

  initial begin
    test_reset();
    test_async_clear();
    test_count_up();
    test_count_down();
    test_load();
    test_hold();
    test_random();
    test_cascade();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
